// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter steering an 8:1 mux, framing each grant as a burst of up to BURST_MAX beats.
// Optional macro MUX8_ARB_LOCK_EN adds lock_i, which holds a grant past BURST_MAX.
module mux8_rr_arbiter #(
   parameter int unsigned BURST_MAX = 4,
   parameter int unsigned CNT_W     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_i,
   input  logic       out_ready_i,
`ifdef MUX8_ARB_LOCK_EN
   input  logic       lock_i,
`endif
   output logic [2:0] sel_o,
   output logic [7:0] gnt_o,
   output logic       out_valid_o,
   output logic       burst_done_o,
   output logic       busy_o
);

   typedef enum logic {StIdle, StXfer} state_e;

   state_e           state_q;
   logic [2:0]       sel_q;
   logic [2:0]       ptr_q;
   logic [7:0]       gnt_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   logic [2:0] scan_start;
   logic [2:0] scan_idx;
   logic [2:0] win;
   logic       accept;
   logic       cnt_last;
   logic       lock_act;
   logic       grant_end;

`ifdef MUX8_ARB_LOCK_EN
   assign lock_act = lock_i;
`else
   assign lock_act = 1'b0;
`endif

   // In XFER a new winner is only used on grant end, so scan from sel+1 there.
   always_comb begin
      scan_start = (state_q == StXfer) ? sel_q + 3'd1 : ptr_q;
      scan_idx   = '0;
      win        = scan_start;
      for (int i = 7; i >= 0; i--) begin
         scan_idx = scan_start + 3'(i);
         if (req_i[scan_idx]) win = scan_idx;
      end
   end

   assign out_valid_o = (state_q == StXfer) && req_i[sel_q];
   assign accept      = out_valid_o && out_ready_i;
   assign cnt_last    = (cnt_q == CNT_W'(BURST_MAX - 1));
   assign grant_end   = (state_q == StXfer) &&
                        (!req_i[sel_q] || (accept && cnt_last && !lock_act));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sel_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (|req_i) begin
                  state_q <= StXfer;
                  sel_q   <= win;
                  gnt_q   <= 8'(1) << win;
                  cnt_q   <= '0;
               end
            end
            StXfer: begin
               if (grant_end) begin
                  ptr_q  <= sel_q + 3'd1;
                  done_q <= 1'b1;
                  if (|req_i) begin
                     sel_q <= win;
                     gnt_q <= 8'(1) << win;
                     cnt_q <= '0;
                  end else begin
                     state_q <= StIdle;
                     gnt_q   <= '0;
                  end
               end else if (accept && !cnt_last) begin
                  // Saturates at BURST_MAX-1 while a locked burst runs on.
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sel_o        = sel_q;
   assign gnt_o        = gnt_q;
   assign burst_done_o = done_q;
   assign busy_o       = (state_q == StXfer);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: directed stimulus queues expected beats {sel, burst_done};
// a monitor pops one entry per accepted beat.
module tb_mux8_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       out_ready;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       out_valid;
   logic       burst_done;
   logic       busy;
`ifdef MUX8_ARB_LOCK_EN
   logic       lock;
   initial lock = 1'b0;
`endif

   mux8_rr_arbiter #(.BURST_MAX(4), .CNT_W(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .out_ready_i  (out_ready),
`ifdef MUX8_ARB_LOCK_EN
      .lock_i       (lock),
`endif
      .sel_o        (sel),
      .gnt_o        (gnt),
      .out_valid_o  (out_valid),
      .burst_done_o (burst_done),
      .busy_o       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   logic [3:0] exp_q[$];   // {sel, burst_done}

   // Monitor: one expected entry per accepted beat, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (burst_done) pulses++;
         if (out_valid && out_ready) begin
            logic [3:0] e;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected: sel=%0d gnt=%h bd=%0d, required no beat",
                        sel, gnt, burst_done);
            end else begin
               e = exp_q.pop_front();
               if (sel != e[3:1] || burst_done != e[0] || gnt != (8'(1) << e[3:1])) begin
                  errors++;
                  $display("FAIL beat: sel=%0d gnt=%h bd=%0d, required sel=%0d gnt=%h bd=%0d",
                           sel, gnt, burst_done, e[3:1], 8'(1) << e[3:1], e[0]);
               end
            end
         end
      end
   end

   task automatic push(input logic [2:0] s, input logic bd, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({s, (i == 0) ? bd : 1'b0});
   endtask

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req_v);
      end
   endtask

   task automatic do_reset();
      req = '0;
      out_ready = 1'b0;
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
   endtask

   task automatic end_test(input string name, input int p0, input int exp_pulses);
      run(3);
      check({name, "_queue_left"}, exp_q.size(), 0);
      check({name, "_pulses"}, pulses - p0, exp_pulses);
      exp_q.delete();
   endtask

   int p0;

   initial begin
      rst_n = 1'b0;
      req = '0;
      out_ready = 1'b0;
      #2;
      do_reset();

      // Reset then idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle", {gnt, out_valid, busy, sel, burst_done}, '0);
      end
      run(1);

      // Single requester: two back-to-back bursts on 2, then release
      do_reset();
      p0 = pulses;
      push(3'd2, 1'b0, 4);
      push(3'd2, 1'b1, 3);
      req = 8'h04;
      out_ready = 1'b1;
      @(negedge clk);
      check("single_idle_before_grant", gnt, 8'h00);
      run(1);
      check("single_gnt", {gnt, 5'b0, sel}, {8'h04, 5'b0, 3'd2});
      run(7);
      req = '0;
      end_test("single", p0, 2);

      // Fairness: 0..7 then 0, four beats each
      do_reset();
      p0 = pulses;
      for (int k = 0; k < 8; k++) push(3'(k), (k != 0), 4);
      push(3'd0, 1'b1, 3);
      req = 8'hFF;
      out_ready = 1'b1;
      run(36);
      req = '0;
      end_test("fair", p0, 9);

      // Backpressure: ready 1,0,0,1,1,0,1
      do_reset();
      p0 = pulses;
      push(3'd0, 1'b0, 4);
      req = 8'h01;
      out_ready = 1'b0;
      run(1);
      out_ready = 1'b1; run(1);
      out_ready = 1'b0; run(1);
      run(1);
      out_ready = 1'b1; run(1);
      run(1);
      out_ready = 1'b0; run(1);
      out_ready = 1'b1; run(1);
      req = '0;
      @(negedge clk);
      check("bp_done_after_4th", {busy, burst_done, gnt}, {1'b1, 1'b1, 8'h01});
      end_test("bp", p0, 2);

      // Early release on 7, wrap to 0
      do_reset();
      p0 = pulses;
      push(3'd7, 1'b0, 1);
      push(3'd0, 1'b1, 2);
      req = 8'h80;
      out_ready = 1'b1;
      run(1);
      check("wrap_gnt7", gnt, 8'h80);
      req = 8'h81;
      run(1);
      req = 8'h01;
      @(negedge clk);
      check("wrap_drop_no_beat", out_valid, 1'b0);
      run(1);
      check("wrap_gnt0", {gnt, 5'b0, sel}, {8'h01, 5'b0, 3'd0});
      run(2);
      req = '0;
      end_test("wrap", p0, 2);

      // Async reset mid-burst on 5
      do_reset();
      p0 = pulses;
      push(3'd5, 1'b0, 2);
      req = 8'h20;
      out_ready = 1'b1;
      run(2);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_outputs", {gnt, out_valid, busy, sel, burst_done}, '0);
      run(1);
      rst_n = 1'b1;
      push(3'd5, 1'b0, 1);
      @(negedge clk);
      check("arst_idle_after_release", busy, 1'b0);
      run(1);
      check("arst_regrant", {gnt, 5'b0, sel}, {8'h20, 5'b0, 3'd5});
      run(1);
      req = '0;
      end_test("arst", p0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
